// File: rtl/serial_adder_mux_pkg.sv
// ============================================================================
// Module      : serial_adder_mux_pkg
// Description : Shared state encoding for the bit-serial adder/subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_adder_mux_pkg;

  // 2'd3 is unused; the FSM folds it back to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage : serial_adder_mux_pkg

`default_nettype wire

// File: rtl/serial_adder_mux_fa.sv
// ============================================================================
// Module      : serial_adder_mux_fa
// Description : 1-bit full adder built from 2:1 multiplexers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder_mux_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  // Propagate selects both muxes: sum inverts ci, carry passes ci or generates a.
  assign p  = a ^ b;
  assign s  = p ? ~ci : ci;
  assign co = p ? ci  : a;

endmodule : serial_adder_mux_fa

`default_nettype wire

// File: rtl/serial_adder_mux.sv
// ============================================================================
// Module      : serial_adder_mux
// Description : LSB-first bit-serial adder/subtractor using one full-adder cell.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder_mux
  import serial_adder_mux_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic fa_s;
  logic fa_co;
  logic accept;
  logic last_bit;

  serial_adder_mux_fa u_fa (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  assign accept   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          // Subtraction is a + ~b + 1: invert b once here and seed the carry.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        s_d     = {fa_s, s_q[WIDTH-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_co;
        cnt_d   = cnt_q + 1'b1;
        if (last_bit) begin
          // carry_q is the carry into the MSB on this edge.
          sum_d   = {fa_s, s_q[WIDTH-1:1]};
          cout_d  = fa_co;
          ovf_d   = carry_q ^ fa_co;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ready    = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign done     = (state_q == ST_DONE);
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule : serial_adder_mux

`default_nettype wire

// File: tb/tb_serial_adder_mux.sv
// ============================================================================
// Module      : tb_serial_adder_mux
// Description : Directed self-checking bench for serial_adder_mux (WIDTH 8 and 2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_adder_mux;

  logic       clk;
  logic       rst_n;

  logic       start8, sub8, cin8;
  logic [7:0] a8, b8;
  logic       ready8, done8, cout8, ovf8;
  logic [7:0] sum8;

  logic       start2, sub2, cin2;
  logic [1:0] a2, b2;
  logic       ready2, done2, cout2, ovf2;
  logic [1:0] sum2;

  int errors;
  int checks;

  serial_adder_mux #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8), .cin(cin8),
    .ready(ready8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8)
  );

  serial_adder_mux #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .sub(sub2), .a(a2), .b(b2), .cin(cin2),
    .ready(ready2), .done(done2), .sum(sum2), .cout(cout2), .overflow(ovf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One WIDTH=8 operation; returns at the negedge where done should be high.
  task automatic run8(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                      input logic tcin, input logic tsub,
                      input logic [7:0] esum, input logic ecout, input logic eovf);
    @(negedge clk);
    chk({tag, "_idle_done"}, 64'(done8), 64'd0);
    chk({tag, "_ready"}, 64'(ready8), 64'd1);
    a8 = ta; b8 = tb_v; cin8 = tcin; sub8 = tsub; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      chk({tag, "_done_t", $sformatf("%0d", i)}, 64'(done8), 64'(i == 8));
    end
    chk({tag, "_sum"}, 64'(sum8), 64'(esum));
    chk({tag, "_cout"}, 64'(cout8), 64'(ecout));
    chk({tag, "_ovf"}, 64'(ovf8), 64'(eovf));
  endtask

  task automatic run2(input logic [1:0] ta, input logic [1:0] tb_v, input logic tcin,
                      input logic tsub, input logic [1:0] esum, input logic ecout,
                      input logic eovf);
    string tag;
    tag = $sformatf("w2_%s_a%0d_b%0d_c%0d", tsub ? "sub" : "add", ta, tb_v, tcin);
    @(negedge clk);
    a2 = ta; b2 = tb_v; cin2 = tcin; sub2 = tsub; start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    for (int i = 0; i <= 2; i++) begin
      @(negedge clk);
      chk({tag, "_done"}, 64'(done2), 64'(i == 2));
    end
    chk({tag, "_sum"}, 64'(sum2), 64'(esum));
    chk({tag, "_cout"}, 64'(cout2), 64'(ecout));
    chk({tag, "_ovf"}, 64'(ovf2), 64'(eovf));
  endtask

  initial begin
    int sa, sb, r, u;
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    start8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
    start2 = 1'b0; sub2 = 1'b0; cin2 = 1'b0; a2 = '0; b2 = '0;

    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(ready8), 64'd1);
    chk("rst_done", 64'(done8), 64'd0);
    chk("rst_sum", 64'(sum8), 64'd0);
    chk("rst_cout", 64'(cout8), 64'd0);
    chk("rst_ovf", 64'(ovf8), 64'd0);
    rst_n = 1'b1;

    run8("add_0f_01", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
    run8("add_ff_01_c1", 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
    run8("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    run8("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    run8("sub_05_07", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);

    // Start pulse during RUN is ignored; start held in DONE chains a new op.
    @(negedge clk);
    a8 = 8'h40; b8 = 8'h02; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i == 3) begin
        chk("run_ready", 64'(ready8), 64'd0);
        a8 = 8'h01; b8 = 8'h01; start8 = 1'b1;
      end
      if (i == 4) start8 = 1'b0;
      chk("ign_done", 64'(done8), 64'(i == 8));
    end
    chk("ign_sum", 64'(sum8), 64'h42);
    a8 = 8'h22; b8 = 8'h11; start8 = 1'b1;
    chk("b2b_ready", 64'(ready8), 64'd1);
    @(posedge clk);
    #1 start8 = 1'b0;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      chk("b2b_done", 64'(done8), 64'(i == 8));
      if (i == 4) chk("b2b_hold_sum", 64'(sum8), 64'h42);
    end
    chk("b2b_sum", 64'(sum8), 64'h33);
    chk("b2b_cout", 64'(cout8), 64'd0);

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", 64'(ready8), 64'd1);
    chk("arst_done", 64'(done8), 64'd0);
    chk("arst_sum", 64'(sum8), 64'd0);
    chk("arst_cout", 64'(cout8), 64'd0);
    chk("arst_ovf", 64'(ovf8), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run8("post_rst", 8'h3C, 8'h0A, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);

    // WIDTH=2 exhaustive sweep against independent signed/unsigned arithmetic.
    for (int s = 0; s < 2; s++) begin
      for (int ia = 0; ia < 4; ia++) begin
        for (int ib = 0; ib < 4; ib++) begin
          for (int c = 0; c < 2 - s; c++) begin
            sa = (ia >= 2) ? ia - 4 : ia;
            sb = (ib >= 2) ? ib - 4 : ib;
            if (s == 0) begin
              u = ia + ib + c;
              r = sa + sb + c;
              run2(2'(ia), 2'(ib), 1'(c), 1'b0, 2'(u), 1'(u >= 4), 1'(r > 1 || r < -2));
            end else begin
              r = sa - sb;
              run2(2'(ia), 2'(ib), 1'b1, 1'b1, 2'(ia - ib), 1'(ia >= ib),
                   1'(r > 1 || r < -2));
            end
          end
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_serial_adder_mux

`default_nettype wire
